// File: rtl/mem_arbiter_if.sv
// Requester and RAM bus of the memory arbiter.
// The master modport is the arbiter's view; slave is the requesters/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              i_hit;
  logic              d_hit;
  logic              i_err;
  logic              d_err;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output i_hit, d_hit, i_err, d_err, iload, dload,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  i_hit, d_hit, i_err, d_err, iload, dload,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests win, a burst limit guarantees instruction
// fetch progress, and a grant timeout turns a stalled RAM into an error completion.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 16
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.master bus
);
  localparam int BCW = $clog2(MAX_D_BURST + 1);
  localparam int TCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t         state, state_next;
  logic [BCW-1:0] burst;
  logic [TCW-1:0] tcount;
  logic           d_pend, go_d, go_i, access, abort;

  always_comb begin
    d_pend     = bus.dREN | bus.dWEN;
    go_d       = 1'b0;
    go_i       = 1'b0;
    access     = 1'b0;
    abort      = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        go_d = d_pend && !(bus.iREN && burst == BCW'(MAX_D_BURST));
        go_i = !go_d && bus.iREN;
        if (go_d)      state_next = DGRANT;
        else if (go_i) state_next = IGRANT;
      end
      DGRANT, IGRANT: begin
        access = (bus.ramstate == RAM_ACCESS);
        abort  = !access && (bus.ramstate == RAM_ERROR || tcount == TCW'(TIMEOUT - 1));
        if (access || abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      burst        <= '0;
      tcount       <= '0;
      bus.i_hit    <= 1'b0;
      bus.d_hit    <= 1'b0;
      bus.i_err    <= 1'b0;
      bus.d_err    <= 1'b0;
      bus.iload    <= '0;
      bus.dload    <= '0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
    end else begin
      bus.i_hit <= 1'b0;
      bus.d_hit <= 1'b0;
      bus.i_err <= 1'b0;
      bus.d_err <= 1'b0;

      // Count data completions only while a fetch is actually waiting.
      if (!bus.iREN || (state == IGRANT && (access || abort)))
        burst <= '0;
      else if (state == DGRANT && (access || abort) && burst != BCW'(MAX_D_BURST))
        burst <= burst + BCW'(1);

      case (state)
        IDLE: begin
          if (go_d || go_i) begin
            bus.ramaddr  <= go_d ? bus.daddr : bus.iaddr;
            bus.ramWEN   <= go_d && bus.dWEN;
            bus.ramREN   <= !(go_d && bus.dWEN);
            bus.ramstore <= bus.dstore;
            tcount       <= '0;
          end
        end
        DGRANT, IGRANT: begin
          if (access || abort) begin
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
            if (state == DGRANT) begin
              bus.d_hit <= 1'b1;
              bus.d_err <= abort;
              if (abort)           bus.dload <= '0;
              else if (bus.ramREN) bus.dload <= bus.ramload;
            end else begin
              bus.i_hit <= 1'b1;
              bus.i_err <= abort;
              bus.iload <= abort ? '0 : bus.ramload;
            end
          end else begin
            tcount <= tcount + TCW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, read, write, timeout, burst fairness, RAM error.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAXB = 4;
  localparam int TMO = 16;

  logic CLK;
  logic nRST;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // {i_hit, d_hit, i_err, d_err, ramREN, ramWEN}
  function automatic logic [5:0] flags();
    return {bus.i_hit, bus.d_hit, bus.i_err, bus.d_err, bus.ramREN, bus.ramWEN};
  endfunction

  task automatic test_reset();
    logic seen;
    nRST = 1'b0;
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0; bus.daddr = '0;
    bus.dstore = '0; bus.ramload = '0; bus.ramstate = 2'd0;
    tick(); tick();
    checks++;
    if ({flags(), bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== '0) begin
      errors++; $display("FAIL reset_state flags=%b addr=%h store=%h", flags(), bus.ramaddr, bus.ramstore);
    end
    nRST = 1'b1;
    bus.dREN = 1; bus.daddr = 32'h80; bus.ramstate = 2'd1;
    tick();
    checks++;
    if (flags() !== 6'b000010 || bus.ramaddr !== 32'h80) begin
      errors++; $display("FAIL t1_grant flags=%b addr=%h exp flags=000010 addr=80", flags(), bus.ramaddr);
    end
    tick();
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (flags() !== 6'b0 || bus.ramaddr !== '0) begin
      errors++; $display("FAIL t1_async_reset flags=%b addr=%h exp 0", flags(), bus.ramaddr);
    end
    bus.dREN = 0;
    tick();
    nRST = 1'b1;
    bus.ramstate = 2'd2;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.d_hit || bus.i_hit || bus.ramREN) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL t1_no_hit_after_release activity=%b exp 0", seen);
    end
    bus.ramstate = 2'd0;
  endtask

  task automatic test_read();
    bus.dREN = 1; bus.daddr = 32'h100; bus.ramload = 32'hDEADBEEF; bus.ramstate = 2'd2;
    tick();
    checks++;
    if (flags() !== 6'b000010 || bus.ramaddr !== 32'h100) begin
      errors++; $display("FAIL t2_grant flags=%b addr=%h exp flags=000010 addr=100", flags(), bus.ramaddr);
    end
    tick();
    checks++;
    if (flags() !== 6'b010000 || bus.dload !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t2_hit flags=%b dload=%h exp flags=010000 dload=deadbeef", flags(), bus.dload);
    end
    bus.dREN = 0; bus.ramstate = 2'd0;
    tick();
    checks++;
    if (flags() !== 6'b0 || bus.ramaddr !== 32'h100 || bus.dload !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t2_idle_hold flags=%b addr=%h dload=%h exp 0/100/deadbeef", flags(), bus.ramaddr, bus.dload);
    end
  endtask

  task automatic test_write();
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h5A5A5A5A;
    bus.ramload = 32'h11111111; bus.ramstate = 2'd2;
    tick();
    checks++;
    if (flags() !== 6'b000001 || bus.ramstore !== 32'h5A5A5A5A || bus.ramaddr !== 32'h200) begin
      errors++; $display("FAIL t6_grant flags=%b store=%h addr=%h exp 000001/5a5a5a5a/200", flags(), bus.ramstore, bus.ramaddr);
    end
    tick();
    checks++;
    if (flags() !== 6'b010000 || bus.dload !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t6_hit flags=%b dload=%h exp 010000/deadbeef", flags(), bus.dload);
    end
    bus.dREN = 0; bus.dWEN = 0; bus.ramstate = 2'd0;
    tick();
  endtask

  task automatic test_timeout();
    logic early;
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = 2'd1;
    tick();
    bus.daddr = 32'hABC;
    early = 1'b0;
    for (int k = 1; k < TMO; k++) begin
      tick();
      if (flags() !== 6'b000010 || bus.ramaddr !== 32'h300) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL t4_wait_stable flags=%b addr=%h exp 000010/300 throughout", flags(), bus.ramaddr);
    end
    tick();
    checks++;
    if (flags() !== 6'b010100 || bus.dload !== 32'h0) begin
      errors++; $display("FAIL t4_timeout flags=%b dload=%h exp 010100/0", flags(), bus.dload);
    end
    bus.dREN = 0; bus.ramstate = 2'd0;
    tick();
    checks++;
    if (flags() !== 6'b0) begin
      errors++; $display("FAIL t4_pulse_one_cycle flags=%b exp 000000", flags());
    end
  endtask

  task automatic test_burst();
    string got;
    string exp;
    int    n;
    logic  i_wen;
    got = ""; exp = "DDDDIDDDDI"; n = 0; i_wen = 1'b0;
    bus.iREN = 1; bus.iaddr = 32'h1000; bus.dWEN = 1; bus.daddr = 32'h2000;
    bus.dstore = 32'h77; bus.ramload = 32'h0BADC0DE; bus.ramstate = 2'd2;
    for (int c = 0; c < 60 && n < 10; c++) begin
      tick();
      if (bus.ramREN || bus.ramWEN) begin
        if (bus.ramaddr == 32'h1000) begin
          got = {got, "I"};
          if (bus.ramWEN || !bus.ramREN) i_wen = 1'b1;
        end else begin
          got = {got, "D"};
        end
        n++;
      end
    end
    checks++;
    if (got != exp) begin
      errors++; $display("FAIL t3_order got=%s exp=%s", got, exp);
    end
    checks++;
    if (i_wen !== 1'b0) begin
      errors++; $display("FAIL t3_i_grant_wen got=%b exp 0", i_wen);
    end
    bus.iREN = 0; bus.dWEN = 0;
    tick(); tick(); tick();
    checks++;
    if (bus.iload !== 32'h0BADC0DE || bus.dload !== 32'h0) begin
      errors++; $display("FAIL t3_loads iload=%h dload=%h exp 0badc0de/0", bus.iload, bus.dload);
    end
    bus.ramstate = 2'd0;
  endtask

  task automatic test_error();
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = 2'd1;
    tick();
    checks++;
    if (flags() !== 6'b000010 || bus.ramaddr !== 32'h40) begin
      errors++; $display("FAIL t5_grant flags=%b addr=%h exp 000010/40", flags(), bus.ramaddr);
    end
    tick(); tick();
    bus.ramstate = 2'd3;
    tick();
    checks++;
    if (flags() !== 6'b101000 || bus.iload !== 32'h0) begin
      errors++; $display("FAIL t5_error flags=%b iload=%h exp 101000/0", flags(), bus.iload);
    end
    bus.iREN = 0; bus.dREN = 1; bus.daddr = 32'h500;
    bus.ramload = 32'hCAFEF00D; bus.ramstate = 2'd2;
    tick();
    checks++;
    if (flags() !== 6'b000010 || bus.ramaddr !== 32'h500) begin
      errors++; $display("FAIL t5_next_grant flags=%b addr=%h exp 000010/500", flags(), bus.ramaddr);
    end
    tick();
    checks++;
    if (flags() !== 6'b010000 || bus.dload !== 32'hCAFEF00D) begin
      errors++; $display("FAIL t5_next_hit flags=%b dload=%h exp 010000/cafef00d", flags(), bus.dload);
    end
    bus.dREN = 0; bus.ramstate = 2'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_burst();
    test_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
